// File: rtl/vga_frame_sequencer_if.sv
// Shared image-ROM read port and VGA adapter write port driven by vga_frame_sequencer.
interface vga_frame_sequencer_if;
    logic [16:0] addr;
    logic [1:0]  layer;
    logic [3:0]  digit;
    logic [2:0]  rom_color;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        write_en;

    modport master (
        output addr, layer, digit, x, y, color, write_en,
        input  rom_color
    );
    modport slave (
        input  addr, layer, digit, x, y, color, write_en,
        output rom_color
    );
endinterface

// File: rtl/vga_frame_sequencer.sv
// Per-frame draw scheduler: background raster, then score digits or a cursor sprite.
// Define VGA_CURSOR_EN to build the cursor pass; otherwise screens 0-2 end after the background.
module vga_frame_sequencer #(
    parameter int unsigned ScrW = 320,
    parameter int unsigned ScrH = 240
) (
    input  logic                  clk,
    input  logic                  iReset,
    input  logic                  vsync_i,
    input  logic [1:0]            screen_i,
    input  logic [15:0]           score_i,
    input  logic [8:0]            cur_x_i,
    input  logic [7:0]            cur_y_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    vga_frame_sequencer_if.master vga
);
    localparam logic [16:0] BgLast = 17'(ScrW * ScrH - 1);
    localparam logic [8:0]  XLast  = 9'(ScrW - 1);
    localparam logic [8:0]  DigX0  = 9'd128;
    localparam logic [7:0]  DigY0  = 8'd112;
    localparam logic [2:0]  Transp = 3'b000;

    typedef enum logic [2:0] {StIdle, StBg, StDig, StCur, StDone} state_e;

    state_e      state_q, state_d;
    logic        vsync_prev_q, start;
    logic [1:0]  screen_q;
    logic [15:0] score_q;
    // Stage 0: the address on the ROM port and the pixel it belongs to.
    logic [16:0] addr_q, addr_d;
    logic [1:0]  layer_q, layer_d;
    logic [3:0]  digit_q, digit_d;
    logic [8:0]  px_q, px_d;
    logic [7:0]  py_q, py_d;
    logic        valid_q, valid_d;
    logic [3:0]  col_q, col_d, row_q, row_d;
    logic [1:0]  dig_q, dig_d;
    logic [2:0]  first_dig, next_dig;
    // Stage 1: adapter write, aligned with the ROM data.
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [2:0]  color_q;
    logic        we_q;
`ifdef VGA_CURSOR_EN
    logic [8:0]  cur_x_q;
    logic [7:0]  cur_y_q;
    logic [9:0]  cx_sum;
    logic [8:0]  cy_sum;
`else
    logic        unused_cur;
    assign unused_cur = ^{cur_x_i, cur_y_i};
`endif

    function automatic logic [3:0] nib(input logic [15:0] s, input logic [1:0] k);
        logic [3:0] r;
        unique case (k)
            2'd0:    r = s[15:12];
            2'd1:    r = s[11:8];
            2'd2:    r = s[7:4];
            default: r = s[3:0];
        endcase
        return r;
    endfunction

    // Lowest drawable digit index >= start; 4 means none left.
    function automatic logic [2:0] find_dig(input logic [15:0] s, input logic [2:0] start);
        logic [2:0] res;
        res = 3'd4;
        for (int k = 3; k >= 0; k--) begin
            if (3'(k) >= start && nib(s, 2'(k)) <= 4'd9) res = 3'(k);
        end
        return res;
    endfunction

    assign start = (state_q == StIdle) && vsync_prev_q && !vsync_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        layer_d   = layer_q;
        digit_d   = digit_q;
        px_d      = px_q;
        py_d      = py_q;
        valid_d   = 1'b0;
        col_d     = col_q;
        row_d     = row_q;
        dig_d     = dig_q;
        first_dig = find_dig(score_q, 3'd0);
        next_dig  = find_dig(score_q, {1'b0, dig_q} + 3'd1);
`ifdef VGA_CURSOR_EN
        cx_sum    = '0;
        cy_sum    = '0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBg;
                    addr_d  = '0;
                    layer_d = 2'd0;
                    px_d    = '0;
                    py_d    = '0;
                    valid_d = 1'b1;
                end
            end
            StBg: begin
                if (addr_q == BgLast) begin
                    col_d = '0;
                    row_d = '0;
                    if (screen_q == 2'd3) begin
                        if (first_dig[2]) state_d = StDone;
                        else begin
                            state_d = StDig;
                            dig_d   = first_dig[1:0];
                        end
                    end else begin
`ifdef VGA_CURSOR_EN
                        state_d = StCur;
`else
                        state_d = StDone;
`endif
                    end
                end else begin
                    addr_d  = addr_q + 17'd1;
                    valid_d = 1'b1;
                    if (px_q == XLast) begin
                        px_d = '0;
                        py_d = py_q + 8'd1;
                    end else begin
                        px_d = px_q + 9'd1;
                    end
                end
            end
            StDig: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'hf) begin
                    row_d = row_q + 4'd1;
                    if (row_q == 4'hf) begin
                        if (next_dig[2]) state_d = StDone;
                        else dig_d = next_dig[1:0];
                    end
                end
            end
            StCur: begin
                col_d = col_q + 4'd1;
                if (col_q[2:0] == 3'd7) begin
                    col_d = '0;
                    row_d = row_q + 4'd1;
                    if (row_q[2:0] == 3'd7) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Sprite passes derive address and pixel from the counters just chosen.
        if (state_d == StDig) begin
            layer_d = 2'd1;
            digit_d = nib(score_q, dig_d);
            addr_d  = {9'd0, row_d, col_d};
            px_d    = DigX0 + {3'b000, dig_d, 4'b0000} + {5'd0, col_d};
            py_d    = DigY0 + {4'd0, row_d};
            valid_d = 1'b1;
        end
`ifdef VGA_CURSOR_EN
        if (state_d == StCur) begin
            layer_d = 2'd2;
            addr_d  = {11'd0, row_d[2:0], col_d[2:0]};
            cx_sum  = {1'b0, cur_x_q} + {7'd0, col_d[2:0]};
            cy_sum  = {1'b0, cur_y_q} + {6'd0, row_d[2:0]};
            px_d    = cx_sum[8:0];
            py_d    = cy_sum[7:0];
            valid_d = (cx_sum < 10'(ScrW)) && (cy_sum < 9'(ScrH));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q      <= StIdle;
            vsync_prev_q <= 1'b1;
            screen_q     <= '0;
            score_q      <= '0;
            addr_q       <= '0;
            layer_q      <= '0;
            digit_q      <= '0;
            px_q         <= '0;
            py_q         <= '0;
            valid_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            dig_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            we_q         <= 1'b0;
`ifdef VGA_CURSOR_EN
            cur_x_q      <= '0;
            cur_y_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            vsync_prev_q <= vsync_i;
            if (start) begin
                screen_q <= screen_i;
                score_q  <= score_i;
`ifdef VGA_CURSOR_EN
                cur_x_q  <= cur_x_i;
                cur_y_q  <= cur_y_i;
`endif
            end
            addr_q  <= addr_d;
            layer_q <= layer_d;
            digit_q <= digit_d;
            px_q    <= px_d;
            py_q    <= py_d;
            valid_q <= valid_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dig_q   <= dig_d;
            x_q     <= px_q;
            y_q     <= py_q;
            color_q <= vga.rom_color;
            we_q    <= valid_q && !(layer_q != 2'd0 && vga.rom_color == Transp);
        end
    end

    assign vga.addr     = addr_q;
    assign vga.layer    = layer_q;
    assign vga.digit    = digit_q;
    assign vga.x        = x_q;
    assign vga.y        = y_q;
    assign vga.color    = color_q;
    assign vga.write_en = we_q;
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = (state_q == StDone);
endmodule
